// File: rtl/sodor_mem_pkg.sv
// Shared encodings for the Sodor scratchpad port arbiter: requester indices,
// memory function/type codes and the arbiter FSM state.
package sodor_mem_pkg;

  localparam int NUM_REQ = 3;

  localparam logic [1:0] REQ_IMEM = 2'd0;
  localparam logic [1:0] REQ_DMEM = 2'd1;
  localparam logic [1:0] REQ_DBG  = 2'd2;

  localparam logic M_XRD = 1'b0;
  localparam logic M_XWR = 1'b1;

  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arbState_e;

endpackage

// File: rtl/sodor_prio_picker.sv
// Three-way combinational priority picker: promoted requesters win (lowest
// index first), otherwise fixed priority debug > port1 > port0.
module sodor_prio_picker
  import sodor_mem_pkg::*;
(
  input  logic [2:0] valid,
  input  logic [2:0] promoted,
  output logic [2:0] grant,
  output logic [1:0] grantIdx
);

  logic [2:0] eligible;

  always_comb begin
    eligible = valid & promoted;
    grant    = 3'b000;
    grantIdx = REQ_IMEM;
    if (|eligible) begin
      if (eligible[REQ_IMEM]) begin
        grant    = 3'b001;
        grantIdx = REQ_IMEM;
      end else if (eligible[REQ_DMEM]) begin
        grant    = 3'b010;
        grantIdx = REQ_DMEM;
      end else begin
        grant    = 3'b100;
        grantIdx = REQ_DBG;
      end
    end else if (valid[REQ_DBG]) begin
      grant    = 3'b100;
      grantIdx = REQ_DBG;
    end else if (valid[REQ_DMEM]) begin
      grant    = 3'b010;
      grantIdx = REQ_DMEM;
    end else if (valid[REQ_IMEM]) begin
      grant    = 3'b001;
      grantIdx = REQ_IMEM;
    end
  end

endmodule

// File: rtl/sodor_mem_port_arbiter.sv
// Shares one scratchpad memory port between instruction fetch, data access and
// debug; one transaction in flight, fixed priority with starvation promotion.
module sodor_mem_port_arbiter
  import sodor_mem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int TYP_W        = 3,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2:0]            req_valid,
  output logic [2:0]            req_ready,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_data,
  input  logic [2:0]            req_fcn,
  input  logic [3*TYP_W-1:0]    req_typ,
  output logic [2:0]            resp_valid,
  output logic [DATA_W-1:0]     resp_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic [DATA_W-1:0]     mem_req_data,
  output logic                  mem_req_fcn,
  output logic [TYP_W-1:0]      mem_req_typ,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_resp_data,
  output logic                  busy
);

  localparam logic [7:0] STARVE_CNT = 8'(STARVE_LIMIT);

  arbState_e stateReg, stateNext;
  logic [1:0]        ownerReg;
  logic [ADDR_W-1:0] addrReg;
  logic [DATA_W-1:0] dataReg;
  logic              fcnReg;
  logic [TYP_W-1:0]  typReg;
  logic [DATA_W-1:0] respDataReg;

  logic [2:0] promoted;
  logic [2:0] grant;
  logic [1:0] grantIdx;
  logic       latch;
  logic       complete;

  logic [ADDR_W-1:0] addrSlice [NUM_REQ];
  logic [DATA_W-1:0] dataSlice [NUM_REQ];
  logic [TYP_W-1:0]  typSlice  [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic [7:0] waitCntReg;

      assign addrSlice[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign dataSlice[gi] = req_data[gi*DATA_W +: DATA_W];
      assign typSlice[gi]  = req_typ[gi*TYP_W +: TYP_W];

      // Counts IDLE cycles lost while requesting; saturates rather than wraps.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          waitCntReg <= 8'd0;
        end else if (!req_valid[gi] || req_ready[gi]) begin
          waitCntReg <= 8'd0;
        end else if (stateReg == ST_IDLE && waitCntReg != 8'hFF) begin
          waitCntReg <= waitCntReg + 8'd1;
        end
      end

      assign promoted[gi] = (waitCntReg >= STARVE_CNT);
    end
  endgenerate

  sodor_prio_picker uPicker (
    .valid    (req_valid),
    .promoted (promoted),
    .grant    (grant),
    .grantIdx (grantIdx)
  );

  always_comb begin
    stateNext     = stateReg;
    req_ready     = 3'b000;
    mem_req_valid = 1'b0;
    latch         = 1'b0;
    complete      = 1'b0;
    case (stateReg)
      ST_IDLE: begin
        // Gated by reset so no accept strobe escapes while held in reset.
        if (!reset && |grant) begin
          req_ready = grant;
          latch     = 1'b1;
          stateNext = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          if (mem_resp_valid) begin
            complete  = 1'b1;
            stateNext = ST_IDLE;
          end else begin
            stateNext = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          complete  = 1'b1;
          stateNext = ST_IDLE;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateReg    <= ST_IDLE;
      ownerReg    <= REQ_IMEM;
      addrReg     <= '0;
      dataReg     <= '0;
      fcnReg      <= 1'b0;
      typReg      <= '0;
      respDataReg <= '0;
    end else begin
      stateReg <= stateNext;
      if (latch) begin
        ownerReg <= grantIdx;
        addrReg  <= addrSlice[grantIdx];
        dataReg  <= dataSlice[grantIdx];
        fcnReg   <= req_fcn[grantIdx];
        typReg   <= typSlice[grantIdx];
      end
      if (complete) begin
        respDataReg <= mem_resp_data;
      end
    end
  end

  assign resp_valid   = complete ? (3'b001 << ownerReg) : 3'b000;
  assign resp_data    = complete ? mem_resp_data : respDataReg;
  assign mem_req_addr = addrReg;
  assign mem_req_data = dataReg;
  assign mem_req_fcn  = fcnReg;
  assign mem_req_typ  = typReg;
  assign busy         = (stateReg != ST_IDLE);

endmodule

// File: tb/tb_sodor_mem_port_arbiter.sv
// Directed bench for sodor_mem_port_arbiter: single read, contention,
// starvation promotion, backpressure, combinational memory and reset.
module tb_sodor_mem_port_arbiter;
  import sodor_mem_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TYP_W  = 3;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [2:0]          req_valid;
  logic [2:0]          req_ready;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*DATA_W-1:0] req_data;
  logic [2:0]          req_fcn;
  logic [3*TYP_W-1:0]  req_typ;
  logic [2:0]          resp_valid;
  logic [DATA_W-1:0]   resp_data;
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic [DATA_W-1:0]   mem_req_data;
  logic                mem_req_fcn;
  logic [TYP_W-1:0]    mem_req_typ;
  logic                mem_resp_valid;
  logic [DATA_W-1:0]   mem_resp_data;
  logic                busy;

  int testsRun  = 0;
  int failCount = 0;

  always #5 clock = ~clock;

  sodor_mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TYP_W(TYP_W), .STARVE_LIMIT(8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_fcn        (req_fcn),
    .req_typ        (req_typ),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_fcn    (mem_req_fcn),
    .mem_req_typ    (mem_req_typ),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic setReq(input int idx, input logic [31:0] a, input logic [31:0] d,
                        input logic f, input logic [2:0] t);
    req_addr[idx*ADDR_W +: ADDR_W] = a;
    req_data[idx*DATA_W +: DATA_W] = d;
    req_fcn[idx]                   = f;
    req_typ[idx*TYP_W +: TYP_W]    = t;
    req_valid[idx]                 = 1'b1;
  endtask

  // One full transaction with a one-cycle memory, starting in an IDLE cycle.
  task automatic serveOne(input string tag, input logic [2:0] expGrant,
                          input logic [31:0] expAddr, input logic [31:0] rdata,
                          input logic [2:0] dropMask);
    settle();
    chk({tag, "_ready"}, 32'(req_ready), 32'(expGrant));
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    nextCycle();
    req_valid     = req_valid & ~dropMask;
    mem_req_ready = 1'b1;
    settle();
    chk({tag, "_mvalid"}, 32'(mem_req_valid), 32'd1);
    chk({tag, "_maddr"}, mem_req_addr, expAddr);
    chk({tag, "_noready"}, 32'(req_ready), 32'd0);
    nextCycle();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = rdata;
    settle();
    chk({tag, "_rvalid"}, 32'(resp_valid), 32'(expGrant));
    chk({tag, "_rdata"}, resp_data, rdata);
    nextCycle();
    mem_resp_valid = 1'b0;
    $display("[TB] txn %s grant=%b addr=0x%0h resp=0x%0h", tag, expGrant, expAddr, rdata);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid      = 3'b000;
    req_addr       = '0;
    req_data       = '0;
    req_fcn        = 3'b000;
    req_typ        = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;

    // Reset state, with a request pending that must not be accepted.
    req_valid[0] = 1'b1;
    #12;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mvalid", 32'(mem_req_valid), 32'd0);
    chk("rst_rvalid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_data, 32'd0);
    chk("rst_maddr", mem_req_addr, 32'd0);
    req_valid = 3'b000;
    nextCycle();
    reset = 1'b0;

    // Single read on port 0.
    setReq(0, 32'h0000_0100, 32'd0, M_XRD, MT_W);
    serveOne("rd", 3'b001, 32'h0000_0100, 32'hDEAD_BEEF, 3'b001);
    settle();
    chk("rd_rvalid_after", 32'(resp_valid), 32'd0);
    chk("rd_rdata_hold", resp_data, 32'hDEAD_BEEF);
    chk("rd_busy_after", 32'(busy), 32'd0);
    nextCycle();

    // Contention: debug, then port1, then port0.
    setReq(0, 32'h1000, 32'd0, M_XRD, MT_W);
    setReq(1, 32'h1100, 32'd0, M_XRD, MT_W);
    setReq(2, 32'h1200, 32'd0, M_XRD, MT_W);
    serveOne("c_dbg", 3'b100, 32'h1200, 32'hAAAA_0002, 3'b100);
    serveOne("c_p1", 3'b010, 32'h1100, 32'hAAAA_0001, 3'b010);
    serveOne("c_p0", 3'b001, 32'h1000, 32'hAAAA_0000, 3'b001);

    // Starvation: port0 and port1 each lose 8 IDLE cycles to debug, then get promoted.
    setReq(0, 32'h2000, 32'd0, M_XRD, MT_W);
    setReq(1, 32'h2100, 32'd0, M_XRD, MT_W);
    setReq(2, 32'h2200, 32'd0, M_XRD, MT_W);
    for (int i = 0; i < 8; i++) begin
      serveOne("s_dbg", 3'b100, 32'h2200, 32'h5000 + 32'(i), 3'b000);
    end
    serveOne("s_p0", 3'b001, 32'h2000, 32'h5100, 3'b001);
    serveOne("s_p1", 3'b010, 32'h2100, 32'h5200, 3'b010);
    req_valid = 3'b000;
    settle();
    chk("s_quiet", 32'(req_ready), 32'd0);
    nextCycle();

    // Backpressure: port1 write held for 5 cycles, port0 waiting behind it.
    setReq(1, 32'h0000_0300, 32'h0000_CAFE, M_XWR, MT_H);
    setReq(0, 32'h0000_0400, 32'h0000_0055, M_XRD, MT_B);
    settle();
    chk("bp_ready", 32'(req_ready), 32'b010);
    nextCycle();
    req_valid[1] = 1'b0;
    req_addr[ADDR_W +: ADDR_W] = 32'hFFFF_FFFF;
    req_data[DATA_W +: DATA_W] = 32'h0BAD_0BAD;
    req_fcn[1] = M_XRD;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("bp_mvalid", 32'(mem_req_valid), 32'd1);
      chk("bp_maddr", mem_req_addr, 32'h0000_0300);
      chk("bp_mdata", mem_req_data, 32'h0000_CAFE);
      chk("bp_mfcn", 32'(mem_req_fcn), 32'(M_XWR));
      chk("bp_mtyp", 32'(mem_req_typ), 32'(MT_H));
      chk("bp_noready", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      nextCycle();
    end
    mem_req_ready = 1'b1;
    settle();
    chk("bp_accept", 32'(mem_req_valid), 32'd1);
    nextCycle();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'd0;
    settle();
    chk("bp_rvalid", 32'(resp_valid), 32'b010);
    nextCycle();
    mem_resp_valid = 1'b0;
    $display("[TB] txn bp_p1 grant=010 addr=0x300 resp=0x0");
    serveOne("bp_p0", 3'b001, 32'h0000_0400, 32'h0000_0077, 3'b001);

    // Combinational memory: accept and respond in the ISSUE cycle.
    setReq(0, 32'h0000_0200, 32'h0000_1234, M_XWR, MT_W);
    settle();
    chk("cm_ready", 32'(req_ready), 32'b001);
    nextCycle();
    req_valid      = 3'b000;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_1234;
    settle();
    chk("cm_mvalid", 32'(mem_req_valid), 32'd1);
    chk("cm_mdata", mem_req_data, 32'h0000_1234);
    chk("cm_mfcn", 32'(mem_req_fcn), 32'(M_XWR));
    chk("cm_rvalid", 32'(resp_valid), 32'b001);
    chk("cm_rdata", resp_data, 32'h0000_1234);
    nextCycle();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    $display("[TB] txn cm grant=001 addr=0x200 resp=0x1234");
    settle();
    chk("cm_idle", 32'(busy), 32'd0);
    chk("cm_rvalid_after", 32'(resp_valid), 32'd0);
    chk("cm_mvalid_after", 32'(mem_req_valid), 32'd0);
    nextCycle();

    // Spurious response in IDLE is ignored.
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_0BAD;
    settle();
    chk("sp_rvalid", 32'(resp_valid), 32'd0);
    chk("sp_rdata", resp_data, 32'h0000_1234);
    nextCycle();
    mem_resp_valid = 1'b0;
    settle();
    chk("sp_busy", 32'(busy), 32'd0);
    chk("sp_rdata_hold", resp_data, 32'h0000_1234);
    nextCycle();

    // Reset while port1 waits for its response.
    setReq(1, 32'h0000_0500, 32'd0, M_XRD, MT_W);
    settle();
    chk("rw_ready", 32'(req_ready), 32'b010);
    nextCycle();
    req_valid     = 3'b000;
    mem_req_ready = 1'b1;
    settle();
    chk("rw_mvalid", 32'(mem_req_valid), 32'd1);
    nextCycle();
    mem_req_ready = 1'b0;
    settle();
    chk("rw_wait_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    setReq(0, 32'h0000_0700, 32'd0, M_XRD, MT_W);
    #1;
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_mvalid0", 32'(mem_req_valid), 32'd0);
    chk("rw_maddr0", mem_req_addr, 32'd0);
    chk("rw_rdata0", resp_data, 32'd0);
    chk("rw_ready0", 32'(req_ready), 32'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_0099;
    #1;
    chk("rw_rvalid0", 32'(resp_valid), 32'd0);
    nextCycle();
    nextCycle();
    reset     = 1'b0;
    req_valid = 3'b000;
    settle();
    chk("rw_late_rvalid", 32'(resp_valid), 32'd0);
    chk("rw_late_busy", 32'(busy), 32'd0);
    chk("rw_late_rdata", resp_data, 32'd0);
    nextCycle();
    mem_resp_valid = 1'b0;
    setReq(1, 32'h0000_0600, 32'd0, M_XRD, MT_W);
    serveOne("rw_fresh", 3'b010, 32'h0000_0600, 32'h0000_6666, 3'b010);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
